pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Stall/flush sequencer for the 5-stage MIPS pipeline. It drives the enable/clear controls of every inter-stage pipeline register (F/D/E/M/W), resolves load-use hazards, and sequences multi-cycle divides, outstanding data-memory accesses and exception flushes. It sits beside the datapath in `myCPU` and is the only source of pipeline-register stall/flush controls.

## Interface
Parameters:
- `CNT_W`, default 32: width of the stall-cycle performance counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `memtoreg_e`  in  1  instruction in E is a load.
- `rs_d`, `rt_d`  in  5  source registers of the instruction in D.
- `rt_e`  in  5  destination of the load in E.
- `div_req_e`  in  1  instruction in E is DIV/DIVU.
- `div_done`  in  1  divider result valid; a one-cycle pulse.
- `div_start`  out  1  one-cycle divider start pulse.
- `div_cancel`  out  1  one-cycle divider abort pulse.
- `data_req_m`  in  1  one-cycle pulse: M issued a data-SRAM request.
- `data_ok`  in  1  data-SRAM response; a one-cycle pulse.
- `excp_m`  in  1  exception or ERET committed in M.
- `pc_redirect`  out  1  PC selects the exception/EPC target.
- `stall_f`, `stall_d`, `stall_e`, `stall_m`, `stall_w`  out  1 each  hold the stage register (`en = ~stall_x`).
- `flush_d`, `flush_e`, `flush_m`, `flush_w`  out  1 each  clear the stage register (`clr`).
- `stall_cycles`  out  `CNT_W`  count of cycles with `stall_f`=1; wraps modulo 2^`CNT_W`.

## Operation
- FSM states: RUN, DIV, MEM. Reset enters RUN.
- Stall/flush outputs are combinational from the current state and inputs.
- Priority within a cycle: `excp_m` > memory wait > divide > load-use.
- **RUN, `excp_m`=1**:
  - Assert `flush_d`, `flush_e`, `flush_m` and `pc_redirect`.
  - No stalls; stay in RUN.
- **RUN, `data_req_m` && !`data_ok`**:
  - Assert `stall_f`..`stall_m` and `flush_w`.
  - Go to MEM.
- **RUN, `data_req_m` && `data_ok`** (same-cycle response): no stall; stay in RUN.
- **RUN, `div_req_e`**:
  - Assert `stall_f`, `stall_d`, `stall_e` and `flush_m`.
  - Go to DIV.
- **RUN, load-use**: condition is `memtoreg_e` && `rt_e`!=0 && (`rt_e`==`rs_d` || `rt_e`==`rt_d`).
  - Assert `stall_f`, `stall_d` and `flush_e`.
  - Stay in RUN.
- **MEM**:
  - Hold `stall_f`..`stall_m` and `flush_w` until `data_ok`.
  - In the `data_ok` cycle, deassert all stalls and return to RUN.
  - `data_req_m` and `excp_m` are ignored in MEM.
- **DIV**:
  - `div_start` is registered and is high only in the first DIV cycle.
  - Hold `stall_f`, `stall_d`, `stall_e` and `flush_m`.
  - On `div_done`, deassert stalls in that same cycle and return to RUN.
  - On `excp_m` in DIV, exception behaviour applies, `div_cancel` pulses, and the next state is RUN. `excp_m` has priority over `div_done`.
- `div_done` outside DIV is ignored. A second `div_req_e` directly after a DIV exit re-enters DIV; back-to-back divides are legal.
- `stall_w` is always 0; it is reserved.

## Timing
- Reset (`resetn`=0, asynchronous): state RUN, `div_start`=0, `stall_cycles`=0.
  - All combinational outputs evaluate as RUN with inputs, but `pc_redirect` and all stalls/flushes are forced to 0 while in reset.
- Load-use costs exactly 1 bubble cycle.
- Divide stall length is (cycles from DIV entry to the `div_done` cycle) + 1, with RUN-cycle entry included.
- Memory stall lasts from the request cycle through the cycle before `data_ok`.
- Exception redirect latency is 0: flush and redirect are asserted in the `excp_m` cycle.
- `stall_cycles` increments at the clock edge ending each cycle in which `stall_f`=1.
- Reset asserted mid-DIV/MEM: return to RUN immediately. No `div_cancel` is issued; the divider is reset by the same `resetn`.

## Test plan
- Load-use: load `$5` in E, `rs_d`=5 → `stall_f`=`stall_d`=`flush_e`=1 for 1 cycle; `rt_e`=0 → no stall; `stall_cycles`=1.
- Divide: `div_req_e` at cycle 0, `div_done` at cycle 5 → `div_start` at cycle 1, `stall_e`=1 for cycles 0–4, RUN at cycle 6.
- Memory: `data_req_m` at cycle 0, `data_ok` at cycle 3 → `stall_m`=`flush_w`=1 for cycles 0–2; same-cycle `data_ok` → no stall.
- Exception during DIV: `excp_m`=1 at the third DIV cycle with `div_done`=1 simultaneously → `div_cancel`=1, `flush_d`/`e`/`m`=1, `pc_redirect`=1, next state RUN.
- Priority: load-use + `div_req_e` + `excp_m` in the same RUN cycle → only exception outputs; no `div_start` in the next cycle.
- Reset mid-MEM: drop `resetn` → all stalls are 0 immediately; after release, `stall_cycles`=0 and state is RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, multi-cycle
// divide, outstanding data-memory waits and exception flush/redirect.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             memtoreg_e,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [4:0]       rt_e,
  input  logic             div_req_e,
  input  logic             div_done,
  output logic             div_start,
  output logic             div_cancel,
  input  logic             data_req_m,
  input  logic             data_ok,
  input  logic             excp_m,
  output logic             pc_redirect,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             stall_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {RUN = 2'd0, DIV = 2'd1, MEM = 2'd2} state_e;

  typedef struct packed {
    logic sf, sd, se, sm;
    logic fd, fe, fm, fw;
    logic redirect, cancel;
  } ctl_t;

  localparam ctl_t CTL_NONE = '0;
  localparam ctl_t CTL_EXCP = '{sf: 1'b0, sd: 1'b0, se: 1'b0, sm: 1'b0,
                                fd: 1'b1, fe: 1'b1, fm: 1'b1, fw: 1'b0,
                                redirect: 1'b1, cancel: 1'b0};
  localparam ctl_t CTL_MEM  = '{sf: 1'b1, sd: 1'b1, se: 1'b1, sm: 1'b1,
                                fd: 1'b0, fe: 1'b0, fm: 1'b0, fw: 1'b1,
                                redirect: 1'b0, cancel: 1'b0};
  localparam ctl_t CTL_DIV  = '{sf: 1'b1, sd: 1'b1, se: 1'b1, sm: 1'b0,
                                fd: 1'b0, fe: 1'b0, fm: 1'b1, fw: 1'b0,
                                redirect: 1'b0, cancel: 1'b0};
  localparam ctl_t CTL_LU   = '{sf: 1'b1, sd: 1'b1, se: 1'b0, sm: 1'b0,
                                fd: 1'b0, fe: 1'b1, fm: 1'b0, fw: 1'b0,
                                redirect: 1'b0, cancel: 1'b0};

  state_e            state_q, state_d;
  logic              div_start_q, div_start_d;
  logic [CNT_W-1:0]  stall_cycles_q;
  ctl_t              ctl;
  logic              load_use;

  assign load_use = memtoreg_e && (rt_e != 5'd0) && ((rt_e == rs_d) || (rt_e == rt_d));

  always_comb begin
    ctl     = CTL_NONE;
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (excp_m) begin
          ctl = CTL_EXCP;
        end else if (data_req_m && !data_ok) begin
          ctl     = CTL_MEM;
          state_d = MEM;
        end else if (div_req_e) begin
          ctl     = CTL_DIV;
          state_d = DIV;
        end else if (load_use) begin
          ctl = CTL_LU;
        end
      end
      MEM: begin
        if (data_ok) state_d = RUN;
        else         ctl     = CTL_MEM;
      end
      DIV: begin
        // exception wins over a simultaneous div_done: the result is discarded
        if (excp_m) begin
          ctl        = CTL_EXCP;
          ctl.cancel = 1'b1;
          state_d    = RUN;
        end else if (div_done) begin
          state_d = RUN;
        end else begin
          ctl = CTL_DIV;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign div_start_d = (state_q != DIV) && (state_d == DIV);

  // controls are forced quiet while reset is held
  assign stall_f     = ctl.sf & resetn;
  assign stall_d     = ctl.sd & resetn;
  assign stall_e     = ctl.se & resetn;
  assign stall_m     = ctl.sm & resetn;
  assign stall_w     = 1'b0;
  assign flush_d     = ctl.fd & resetn;
  assign flush_e     = ctl.fe & resetn;
  assign flush_m     = ctl.fm & resetn;
  assign flush_w     = ctl.fw & resetn;
  assign pc_redirect = ctl.redirect & resetn;
  assign div_cancel  = ctl.cancel & resetn;
  assign div_start   = div_start_q;
  assign stall_cycles = stall_cycles_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= RUN;
      div_start_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      div_start_q    <= div_start_d;
      stall_cycles_q <= stall_cycles_q + CNT_W'(stall_f);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, multi-cycle corner
// sequences and randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic memtoreg_e, div_req_e, div_done, data_req_m, data_ok, excp_m;
  logic [4:0] rs_d, rt_d, rt_e;
  logic div_start, div_cancel, pc_redirect;
  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_d, flush_e, flush_m, flush_w;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .memtoreg_e(memtoreg_e), .rs_d(rs_d), .rt_d(rt_d),
    .rt_e(rt_e), .div_req_e(div_req_e), .div_done(div_done), .div_start(div_start),
    .div_cancel(div_cancel), .data_req_m(data_req_m), .data_ok(data_ok), .excp_m(excp_m),
    .pc_redirect(pc_redirect), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .stall_m(stall_m), .stall_w(stall_w), .flush_d(flush_d), .flush_e(flush_e),
    .flush_m(flush_m), .flush_w(flush_w), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic       mem;
    logic [4:0] rs, rt, rte;
    logic       dreq, ddone, req, ok, excp;
  } in_t;

  typedef struct {
    in_t         in;
    logic [11:0] exp;
  } vec_t;

  // {div_start, div_cancel, pc_redirect, sf, sd, se, sm, sw, fd, fe, fm, fw}
  localparam logic [11:0] O_NONE = 12'b000_00000_0000;
  localparam logic [11:0] O_LU   = 12'b000_11000_0100;
  localparam logic [11:0] O_DIV  = 12'b000_11100_0010;
  localparam logic [11:0] O_DIV1 = 12'b100_11100_0010;
  localparam logic [11:0] O_MEM  = 12'b000_11110_0001;
  localparam logic [11:0] O_EXC  = 12'b001_00000_1110;
  localparam logic [11:0] O_EXCD = 12'b011_00000_1110;

  wire [11:0] dut_o = {div_start, div_cancel, pc_redirect, stall_f, stall_d, stall_e,
                       stall_m, stall_w, flush_d, flush_e, flush_m, flush_w};

  // model: which long operation the pipeline is currently waiting on
  bit m_in_div, m_div_first, m_wait_mem;
  int unsigned m_stalls;
  int cyc = 0;

  function automatic in_t mk(bit mem, int rs, int rt, int rte, bit dreq, bit ddone,
                             bit req, bit ok, bit excp);
    in_t v;
    v.mem = mem; v.rs = 5'(rs); v.rt = 5'(rt); v.rte = 5'(rte);
    v.dreq = dreq; v.ddone = ddone; v.req = req; v.ok = ok; v.excp = excp;
    return v;
  endfunction

  function automatic logic [11:0] model_out(in_t v);
    logic [11:0] o;
    bit lu;
    lu = v.mem && v.rte != 0 && (v.rte == v.rs || v.rte == v.rt);
    o = O_NONE;
    if (m_wait_mem) begin
      if (!v.ok) o = O_MEM;
    end else if (m_in_div) begin
      if (v.excp)        o = O_EXCD;
      else if (!v.ddone) o = O_DIV;
      if (m_div_first)   o[11] = 1'b1;
    end else if (v.excp)          o = O_EXC;
    else if (v.req && !v.ok)      o = O_MEM;
    else if (v.dreq)              o = O_DIV;
    else if (lu)                  o = O_LU;
    return o;
  endfunction

  task automatic model_advance(in_t v, logic [11:0] o);
    bit was_div;
    was_div = m_in_div;
    m_stalls += o[8];
    if (m_wait_mem)    m_wait_mem = !v.ok;
    else if (m_in_div) m_in_div = !(v.excp || v.ddone);
    else if (!v.excp) begin
      if (v.req && !v.ok) m_wait_mem = 1;
      else if (v.dreq)    m_in_div = 1;
    end
    m_div_first = m_in_div && !was_div;
  endtask

  task automatic model_reset();
    m_in_div = 0; m_div_first = 0; m_wait_mem = 0; m_stalls = 0;
  endtask

  task automatic drive(in_t v);
    memtoreg_e = v.mem; rs_d = v.rs; rt_d = v.rt; rt_e = v.rte;
    div_req_e = v.dreq; div_done = v.ddone; data_req_m = v.req; data_ok = v.ok; excp_m = v.excp;
  endtask

  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  // one clock: drive after the edge, compare mid-cycle, advance model at the edge
  task automatic cycle(in_t v, bit has_tab, logic [11:0] tab, string nm);
    logic [11:0] e;
    drive(v);
    @(negedge clk);
    e = model_out(v);
    check({nm, "_model"}, 32'(dut_o), 32'(e));
    check({nm, "_cnt"}, stall_cycles, m_stalls);
    if (has_tab) check({nm, "_tab"}, 32'(dut_o), 32'(tab));
    @(posedge clk);
    model_advance(v, e);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    drive('0);
    resetn = 0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1;
    @(posedge clk); #1;
  endtask

  vec_t tab[$];
  in_t idle;

  initial begin
    idle = '0;
    tab.push_back('{mk(0,0,0,0, 0,0,0,0,0), O_NONE});
    tab.push_back('{mk(1,5,3,5, 0,0,0,0,0), O_LU});
    tab.push_back('{mk(1,0,0,0, 0,0,0,0,0), O_NONE});
    tab.push_back('{mk(1,2,7,7, 0,0,0,0,0), O_LU});
    tab.push_back('{mk(0,0,0,0, 1,0,0,0,0), O_DIV});
    tab.push_back('{mk(0,0,0,0, 1,0,0,0,0), O_DIV1});
    tab.push_back('{mk(0,0,0,0, 0,0,0,0,0), O_DIV});
    tab.push_back('{mk(0,0,0,0, 0,1,0,0,0), O_NONE});
    tab.push_back('{mk(0,0,0,0, 0,0,1,0,0), O_MEM});
    tab.push_back('{mk(0,0,0,0, 0,0,1,0,1), O_MEM});
    tab.push_back('{mk(1,5,5,5, 0,0,0,1,0), O_NONE});
    tab.push_back('{mk(0,0,0,0, 0,0,1,1,0), O_NONE});
    tab.push_back('{mk(0,0,0,0, 0,1,0,0,1), O_EXC});
    tab.push_back('{mk(1,4,4,4, 1,0,0,0,1), O_EXC});
    tab.push_back('{mk(0,0,0,0, 0,0,0,0,0), O_NONE});

    drive('0);
    #2;
    check("reset_outs", 32'(dut_o), 32'(O_NONE));
    check("reset_cnt", stall_cycles, 0);
    do_reset();

    foreach (tab[i]) cycle(tab[i].in, 1, tab[i].exp, $sformatf("vec%0d", i));
    check("tab_stall_total", stall_cycles, 7);

    // divide: request at cycle 0, done at cycle 5
    do_reset();
    cycle(mk(0,0,0,0, 1,0,0,0,0), 1, O_DIV, "div_c0");
    cycle(idle, 1, O_DIV1, "div_c1");
    for (int i = 2; i < 5; i++) cycle(idle, 1, O_DIV, "div_mid");
    cycle(mk(0,0,0,0, 0,1,0,0,0), 1, O_NONE, "div_done");
    check("div_stall_len", stall_cycles, 5);
    cycle(mk(0,0,0,0, 1,0,0,0,0), 1, O_DIV, "div_b2b");
    cycle(idle, 1, O_DIV1, "div_b2b_start");
    cycle(mk(0,0,0,0, 0,1,0,0,0), 1, O_NONE, "div_b2b_done");

    // memory: request at 0, response at 3
    do_reset();
    cycle(mk(0,0,0,0, 0,0,1,0,0), 1, O_MEM, "mem_c0");
    cycle(idle, 1, O_MEM, "mem_c1");
    cycle(idle, 1, O_MEM, "mem_c2");
    cycle(mk(0,0,0,0, 0,0,0,1,0), 1, O_NONE, "mem_ok");
    check("mem_stall_len", stall_cycles, 3);
    cycle(idle, 1, O_NONE, "mem_after");

    // exception with div_done on the third DIV cycle
    do_reset();
    cycle(mk(0,0,0,0, 1,0,0,0,0), 1, O_DIV, "xd_c0");
    cycle(idle, 1, O_DIV1, "xd_c1");
    cycle(idle, 1, O_DIV, "xd_c2");
    cycle(mk(0,0,0,0, 0,1,0,0,1), 1, O_EXCD, "xd_excp");
    cycle(mk(1,9,0,9, 0,0,0,0,0), 1, O_LU, "xd_run");

    // reset asserted while waiting on memory
    do_reset();
    cycle(mk(0,0,0,0, 0,0,1,0,0), 1, O_MEM, "rm_c0");
    drive(idle);
    resetn = 0;
    #1;
    check("rm_async_outs", 32'(dut_o), 32'(O_NONE));
    check("rm_async_cnt", stall_cycles, 0);
    model_reset();
    @(negedge clk);
    resetn = 1;
    @(posedge clk); #1;
    cycle(idle, 1, O_NONE, "rm_idle");
    cycle(mk(1,3,0,3, 0,0,0,0,0), 1, O_LU, "rm_run");

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_t v;
      v.mem   = 1'($urandom_range(0, 1));
      v.rte   = 5'($urandom_range(0, 3));
      v.rs    = 5'($urandom_range(0, 3));
      v.rt    = 5'($urandom_range(0, 3));
      v.dreq  = ($urandom_range(0, 7) == 0);
      v.ddone = ($urandom_range(0, 3) == 0);
      v.req   = ($urandom_range(0, 7) == 0);
      v.ok    = ($urandom_range(0, 2) == 0);
      v.excp  = ($urandom_range(0, 15) == 0);
      cycle(v, 0, O_NONE, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
